// File: rtl/mem_arb2_pkg.sv
// Shared state encoding and bus widths for the two-port memory arbiter.
package mem_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int MI_LEN_W = 7;
    localparam int MI_DW    = 32;

endpackage

// File: rtl/mem_arb2_pick.sv
// Two-way picker: one-hot grant from request valids; a tie goes to the port named by ptr.
module mem_arb2_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arb2.sv
// Two-requester burst arbiter onto a single memory-interface port, one burst in flight.
// Define MEM_ARB2_RR_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module mem_arb2
    import mem_arb2_pkg::*;
#(
    parameter  int AW = 20,
    localparam int AL = AW - 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [AL:0]         m0_addr,
    input  logic [MI_LEN_W-1:0] m0_len,
    input  logic                m0_rw,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [MI_DW-1:0]    m0_wdata,
    output logic                m0_wack,
    output logic                m0_wlast,
    output logic [MI_DW-1:0]    m0_rdata,
    output logic                m0_rstb,
    output logic                m0_rlast,

    input  logic [AL:0]         m1_addr,
    input  logic [MI_LEN_W-1:0] m1_len,
    input  logic                m1_rw,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [MI_DW-1:0]    m1_wdata,
    output logic                m1_wack,
    output logic                m1_wlast,
    output logic [MI_DW-1:0]    m1_rdata,
    output logic                m1_rstb,
    output logic                m1_rlast,

    output logic [AL:0]         mi_addr,
    output logic [MI_LEN_W-1:0] mi_len,
    output logic                mi_rw,
    output logic                mi_valid,
    input  logic                mi_ready,
    output logic [MI_DW-1:0]    mi_wdata,
    input  logic                mi_wack,
    input  logic                mi_wlast,
    input  logic [MI_DW-1:0]    mi_rdata,
    input  logic                mi_rstb,
    input  logic                mi_rlast
);

    state_t              state, state_nxt;
    logic                gnt;
    logic                ptr;
    logic [AL:0]         addr_q;
    logic [MI_LEN_W-1:0] len_q;
    logic                rw_q;
    logic [1:0]          pick;
    logic                accept;
    logic                done;
    logic                busy;
    logic                in_data;

    mem_arb2_pick u_pick (
        .valid ({m1_valid, m0_valid}),
        .ptr   (ptr),
        .grant (pick)
    );

`ifdef MEM_ARB2_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~gnt;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    accept    = 1'b1;
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (mi_ready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                // Burst length is never counted; only the qualified last flag ends it.
                done = rw_q ? (mi_rstb & mi_rlast) : (mi_wack & mi_wlast);
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            rw_q   <= 1'b0;
        end else if (accept) begin
            gnt    <= pick[1];
            addr_q <= pick[1] ? m1_addr : m0_addr;
            len_q  <= pick[1] ? m1_len  : m0_len;
            rw_q   <= pick[1] ? m1_rw   : m0_rw;
        end
    end

    assign busy    = (state == ST_CMD) || (state == ST_DATA);
    assign in_data = (state == ST_DATA);

    // rst_n gating keeps ready and the read bus quiet while reset is held.
    assign m0_ready = rst_n & (state == ST_IDLE) & pick[0];
    assign m1_ready = rst_n & (state == ST_IDLE) & pick[1];

    assign mi_addr  = addr_q;
    assign mi_len   = len_q;
    assign mi_rw    = rw_q;
    assign mi_valid = (state == ST_CMD);
    assign mi_wdata = busy ? (gnt ? m1_wdata : m0_wdata) : '0;

    assign m0_wack  = in_data & ~gnt & mi_wack;
    assign m0_wlast = in_data & ~gnt & mi_wack & mi_wlast;
    assign m0_rstb  = in_data & ~gnt & mi_rstb;
    assign m0_rlast = in_data & ~gnt & mi_rstb & mi_rlast;
    assign m1_wack  = in_data &  gnt & mi_wack;
    assign m1_wlast = in_data &  gnt & mi_wack & mi_wlast;
    assign m1_rstb  = in_data &  gnt & mi_rstb;
    assign m1_rlast = in_data &  gnt & mi_rstb & mi_rlast;

    assign m0_rdata = rst_n ? mi_rdata : '0;
    assign m1_rdata = rst_n ? mi_rdata : '0;

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter AW, default 20, memory word-address width; AL = AW-1 derived.
REQ-002 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have, for N in {0,1}: mN_addr in AW; mN_len in 7 (beats-1); mN_rw in 1 (1=read); mN_valid in 1; mN_ready out 1.
REQ-005 SHALL have, for N in {0,1}: mN_wdata in 32; mN_wack out 1; mN_wlast out 1; mN_rdata out 32; mN_rstb out 1; mN_rlast out 1.
REQ-006 SHALL have downstream mi_addr out AW, mi_len out 7, mi_rw out 1, mi_valid out 1, mi_ready in 1.
REQ-007 SHALL have mi_wdata out 32, mi_wack in 1, mi_wlast in 1, mi_rdata in 32, mi_rstb in 1, mi_rlast in 1.

Function
REQ-008 SHALL arbitrate two upstream requesters onto one memory-interface port, one burst outstanding at a time.
REQ-009 SHALL implement FSM states ST_IDLE, ST_CMD, ST_DATA.
REQ-010 ST_IDLE: if any mN_valid, SHALL assert mN_ready combinationally for exactly the winning port, register its addr/len/rw and the grant, go to ST_CMD.
REQ-011 ST_CMD: SHALL drive mi_valid=1 with registered command, held stable until mi_ready=1, then go to ST_DATA.
REQ-012 ST_DATA: SHALL return to ST_IDLE on mi_wack&mi_wlast (write) or mi_rstb&mi_rlast (read).
REQ-013 Latency: request accepted in cycle t SHALL give mi_valid at t+1; next mN_ready no earlier than cycle after burst last.
REQ-014 mi_wdata SHALL equal granted port's mN_wdata in ST_CMD/ST_DATA, else 0.
REQ-015 mN_wack/mN_wlast/mN_rstb/mN_rlast SHALL pass through only to the granted port in ST_DATA; non-granted port sees 0.
REQ-016 mN_rdata SHALL be mi_rdata broadcast to both ports.
REQ-017 mN_ready SHALL be 0 outside ST_IDLE; upstream holds mN_valid and command stable until mN_ready.
REQ-018 Beat counting SHALL NOT be done; burst end determined solely by last flags.
REQ-019 Both ports valid same cycle: winner per REQ-024/025; loser keeps waiting, no request lost.
REQ-020 Last flag without matching strobe, or strobes in ST_IDLE/ST_CMD, SHALL be ignored.

Reset
REQ-021 rst_n low SHALL immediately force ST_IDLE, grant=port 0, priority pointer=port 0, command registers 0.
REQ-022 During and after reset all outputs SHALL be 0 except mN_ready per REQ-010 after release.
REQ-023 Reset mid-burst SHALL abandon the burst; late beats from memory SHALL be dropped (no grant).

Configuration
REQ-024 With MEM_ARB2_RR_EN defined: round-robin; pointer moves to other port after each granted burst; tie goes to pointer port.
REQ-025 Without MEM_ARB2_RR_EN: fixed priority, port 0 always wins ties; pointer logic absent.

Structure
REQ-026 Shared package mem_arb2_pkg SHALL hold state encodings (ST_IDLE=0, ST_CMD=1, ST_DATA=2) and MI_LEN_W=7, MI_DW=32.
REQ-027 SHALL instantiate one sub-module mem_arb2_pick: 2-way picker (valids, pointer -> one-hot grant).

Verification
REQ-028 m0 read addr 0x00100 len 3, memory model with 6-cycle read lag -> mi_valid next cycle, m0 gets 4 rstb beats, rlast on 4th, m1_rstb stays 0.
REQ-029 m1 write addr 0x00040 len 0 data 0xCAFEF00D -> single mi_wack+mi_wlast routed to m1, mem[0x40]=0xCAFEF00D.
REQ-030 m0,m1 valid same cycle, RR_EN defined, 4 back-to-back bursts each -> grants alternate 0,1,0,1...; without macro -> all m0 bursts first.
REQ-031 mi_ready held 0 for 5 cycles in ST_CMD -> mi_addr/len/rw/valid stable all 5 cycles, mN_ready stays 0.
REQ-032 rst_n asserted mid read burst (beat 2 of 8) -> outputs 0 same cycle, remaining rstb beats not forwarded, next m1 request served normally.
